// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: shared constants and types for the receive-side block loader.
//   BLOCK_BYTES : bytes per assembled cipher block
//   BLOCK_W     : width of an assembled block in bits
//   state_e     : loader state (FILL collects bytes, HOLD presents a block)
package rx_ctrl_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : rx_ctrl_pkg

// File: rtl/rx_block_loader.sv
// rx_block_loader: pops bytes from rx_fifo and packs them into 128-bit blocks
// for the AES core. A flush emits a zero-padded partial block marked last; an
// abort discards the partial block. A completed block is always delivered.
// Ports:
//   clk           : clock, rising edge
//   n_rst         : synchronous active-low reset
//   fifo_empty    : rx_fifo empty flag
//   fifo_r_data   : rx_fifo head byte (valid when fifo_empty=0)
//   fifo_r_enable : pop request to rx_fifo (combinational)
//   flush         : request end-of-packet emission of the partial block
//   abort         : discard the partial block (ignored while holding)
//   block_data    : assembled block, first byte popped in [127:120]
//   block_valid   : block_data/block_last valid
//   block_ready   : consumer accept
//   block_last    : final block of a flushed packet
//   byte_count    : bytes held in the current block (0..16)
module rx_block_loader
  import rx_ctrl_pkg::state_e;
  import rx_ctrl_pkg::FILL;
  import rx_ctrl_pkg::HOLD;
  import rx_ctrl_pkg::BLOCK_W;
#(
  parameter int BLOCK_BYTES = rx_ctrl_pkg::BLOCK_BYTES
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_r_data,
  output logic               fifo_r_enable,
  input  logic               flush,
  input  logic               abort,
  output logic [BLOCK_W-1:0] block_data,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_last,
  output logic [4:0]         byte_count
);

  localparam logic [4:0] LAST_LANE = 5'(BLOCK_BYTES - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               flush_pend_q, flush_pend_d;
  logic               pop_s;

  // Pop only while collecting; abort wins over a pop. Gating with n_rst keeps
  // the FIFO untouched while the loader is held in reset.
  assign pop_s = n_rst & (state_q == FILL) & ~fifo_empty & ~abort;
  assign fifo_r_enable = pop_s;

  assign block_data  = data_q;
  assign block_valid = (state_q == HOLD);
  assign block_last  = last_q;
  assign byte_count  = cnt_q;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    flush_pend_d = flush_pend_q | flush;
    case (state_q)
      FILL: begin
        if (abort) begin
          data_d       = '0;
          cnt_d        = 5'd0;
          flush_pend_d = 1'b0;
        end else if (pop_s) begin
          data_d[BLOCK_W-1-8*int'(cnt_q) -: 8] = fifo_r_data;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_LANE) begin
            state_d = HOLD;
            // A flush already pending when the final lane fills closes the
            // packet with this block.
            if (flush_pend_q) begin
              last_d       = 1'b1;
              flush_pend_d = flush;
            end else begin
              last_d = 1'b0;
            end
          end else begin
            state_d = FILL;
          end
        end else if (flush_pend_q && fifo_empty) begin
          // Unwritten lanes are already zero (cleared on handshake/abort),
          // so the partial block goes out padded without extra logic.
          if (cnt_q != 5'd0) begin
            state_d = HOLD;
            last_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
          flush_pend_d = flush;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (block_ready) begin
          state_d = FILL;
          data_d  = '0;
          cnt_d   = 5'd0;
          last_d  = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d      = FILL;
        data_d       = '0;
        cnt_d        = 5'd0;
        last_d       = 1'b0;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= FILL;
      data_q       <= '0;
      cnt_q        <= 5'd0;
      last_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule : rx_block_loader

// File: tb/tb_rx_block_loader.sv
// Directed bench for rx_block_loader with a simple FIFO model on the read side.
module tb_rx_block_loader;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         fifo_empty;
  logic [7:0]   fifo_r_data;
  logic         fifo_r_enable;
  logic         flush;
  logic         abort;
  logic [127:0] block_data;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic [4:0]   byte_count;

  int total = 0;
  int bad   = 0;

  // FIFO model: bench writes, loader pops
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_r_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_r_enable && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
  end

  always #5 clk = ~clk;

  rx_block_loader #(.BLOCK_BYTES(16)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .flush         (flush),
    .abort         (abort),
    .block_data    (block_data),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_last    (block_last),
    .byte_count    (byte_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_empty(input int max);
    int c = 0;
    while (!fifo_empty && c < max) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_valid(input int max, output int cyc, output int pops);
    cyc  = 0;
    pops = 0;
    while (!block_valid && cyc < max) begin
      if (fifo_r_enable) pops++;
      tick();
      cyc++;
    end
  endtask

  localparam logic [127:0] EXP_SEQ0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] EXP_A1   = 128'hA1A2A3A4A50000000000000000000000;
  localparam logic [127:0] EXP_SEQ1 = 128'h101112131415161718191A1B1C1D1E1F;

  initial begin
    int cyc;
    int pops;
    logic stable;
    logic en_seen;
    logic v_seen;

    n_rst = 1'b0;
    flush = 1'b0;
    abort = 1'b0;
    block_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 128'(block_valid), 128'd0);
    chk("rst_count", 128'(byte_count), 128'd0);
    chk("rst_data", block_data, 128'd0);
    chk("rst_last", 128'(block_last), 128'd0);
    chk("rst_ren", 128'(fifo_r_enable), 128'd0);
    n_rst = 1'b1;

    // Full block, consumer always ready
    block_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    #1;
    wait_valid(40, cyc, pops);
    chk("full_pops", 128'(pops), 128'd16);
    chk("full_cycles", 128'(cyc), 128'd16);
    chk("full_valid", 128'(block_valid), 128'd1);
    chk("full_data", block_data, EXP_SEQ0);
    chk("full_last", 128'(block_last), 128'd0);
    chk("full_count", 128'(byte_count), 128'd16);
    tick();
    chk("hs_valid", 128'(block_valid), 128'd0);
    chk("hs_data", block_data, 128'd0);
    chk("hs_count", 128'(byte_count), 128'd0);
    block_ready = 1'b0;

    // Partial block closed by flush
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    #1;
    wait_empty(20);
    tick();
    chk("part_count", 128'(byte_count), 128'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid(10, cyc, pops);
    chk("flush_valid", 128'(block_valid), 128'd1);
    chk("flush_data", block_data, EXP_A1);
    chk("flush_last", 128'(block_last), 128'd1);

    // Back-pressure in HOLD with bytes waiting in the FIFO
    push(8'h55); push(8'h66); push(8'h77);
    stable  = 1'b1;
    en_seen = 1'b0;
    repeat (10) begin
      tick();
      if (block_data !== EXP_A1 || !block_valid || !block_last) stable = 1'b0;
      if (fifo_r_enable) en_seen = 1'b1;
    end
    chk("hold_stable", 128'(stable), 128'd1);
    chk("hold_no_pop", 128'(en_seen), 128'd0);
    chk("hold_occupancy", 128'(wr_ptr - rd_ptr), 128'd3);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    chk("hs2_valid", 128'(block_valid), 128'd0);
    chk("hs2_last", 128'(block_last), 128'd0);

    // Seven bytes then abort; only the following full block appears
    push(8'h88); push(8'h99); push(8'hAA); push(8'hBB);
    #1;
    wait_empty(20);
    tick();
    chk("pre_abort_count", 128'(byte_count), 128'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_count", 128'(byte_count), 128'd0);
    chk("abort_data", block_data, 128'd0);
    chk("abort_valid", 128'(block_valid), 128'd0);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    #1;
    wait_valid(40, cyc, pops);
    chk("post_abort_pops", 128'(pops), 128'd16);
    chk("post_abort_data", block_data, EXP_SEQ1);
    chk("post_abort_last", 128'(block_last), 128'd0);

    // Abort while holding is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hold_abort_valid", 128'(block_valid), 128'd1);
    chk("hold_abort_data", block_data, EXP_SEQ1);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    chk("hs3_valid", 128'(block_valid), 128'd0);

    // Flush with nothing held: no block, and the pending flag must not linger
    flush = 1'b1;
    tick();
    flush = 1'b0;
    v_seen = 1'b0;
    repeat (4) begin
      tick();
      if (block_valid) v_seen = 1'b1;
    end
    push(8'h01); push(8'h02); push(8'h03);
    repeat (8) begin
      tick();
      if (block_valid) v_seen = 1'b1;
    end
    chk("empty_flush_novalid", 128'(v_seen), 128'd0);
    chk("empty_flush_count", 128'(byte_count), 128'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Reset mid-fill
    for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
    #1;
    wait_empty(20);
    tick();
    chk("midfill_count", 128'(byte_count), 128'd9);
    n_rst = 1'b0;
    tick();
    chk("mrst_valid", 128'(block_valid), 128'd0);
    chk("mrst_count", 128'(byte_count), 128'd0);
    chk("mrst_data", block_data, 128'd0);
    chk("mrst_last", 128'(block_last), 128'd0);
    chk("mrst_ren", 128'(fifo_r_enable), 128'd0);
    n_rst = 1'b1;
    tick();

    // Reset mid-HOLD
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    #1;
    wait_valid(40, cyc, pops);
    chk("pre_hrst_valid", 128'(block_valid), 128'd1);
    n_rst = 1'b0;
    tick();
    chk("hrst_valid", 128'(block_valid), 128'd0);
    chk("hrst_data", block_data, 128'd0);
    chk("hrst_count", 128'(byte_count), 128'd0);
    n_rst = 1'b1;
    tick();
    chk("hrst_stay_idle", 128'(block_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rx_block_loader

// File: doc/rx_block_loader.md
RX_BLOCK_LOADER -- requirements
Module: rx_block_loader

Interface
REQ-001 Parameter BLOCK_BYTES, default 16, SHALL set the number of bytes per assembled block; only the value 16 is supported.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port n_rst, input, 1 bit, SHALL be the synchronous, active-low reset.
REQ-004 Port fifo_empty, input, 1 bit, SHALL be the empty flag from rx_fifo.
REQ-005 Port fifo_r_data, input, 8 bits, SHALL be the head byte of rx_fifo, valid whenever fifo_empty=0.
REQ-006 Port fifo_r_enable, output, 1 bit, SHALL pop one byte from rx_fifo at the next clk edge.
REQ-007 Port flush, input, 1 bit, SHALL request single-cycle end-of-packet emission of any partial block.
REQ-008 Port abort, input, 1 bit, SHALL request single-cycle discard of the partial block.
REQ-009 Port block_data, output, 128 bits, SHALL carry the assembled block; first byte popped in [127:120].
REQ-010 Port block_valid, output, 1 bit, SHALL mark block_data and block_last as valid.
REQ-011 Port block_ready, input, 1 bit, SHALL be the consumer (AES core) accept signal.
REQ-012 Port block_last, output, 1 bit, SHALL mark the final block of a flushed packet.
REQ-013 Port byte_count, output, 5 bits, SHALL report bytes held in the current block (0..16).

Function
REQ-014 The block SHALL implement states FILL and HOLD, plus a pending-flush flag flush_pend.
REQ-015 In FILL with fifo_empty=0 and abort=0, the block SHALL assert fifo_r_enable combinationally.
REQ-016 In FILL, each pop SHALL shift fifo_r_data into the next byte lane and increment byte_count, one byte per cycle.
REQ-017 The 16th pop SHALL move the block to HOLD on the same edge, so block_valid=1 the following cycle, with byte_count=16.
REQ-018 In HOLD, fifo_r_enable SHALL be 0, and block_data and block_last SHALL remain stable until block_valid&&block_ready.
REQ-019 On handshake, the block SHALL go to FILL with byte_count=0 and block_data cleared; no pop occurs in the handshake cycle.
REQ-020 flush SHALL set flush_pend, which remains set until consumed.
REQ-021 In FILL with flush_pend=1 and fifo_empty=1, if byte_count>0, the block SHALL zero-pad the remaining lanes, enter HOLD with block_last=1, and clear flush_pend.
REQ-022 In FILL with flush_pend=1, fifo_empty=1 and byte_count=0, the block SHALL clear flush_pend and emit nothing.
REQ-023 If a full block enters HOLD while flush_pend=1 and fifo_empty=1, the block SHALL set block_last=1 and clear flush_pend.
REQ-024 abort in FILL SHALL zero byte_count and block_data and clear flush_pend; no pop occurs that cycle, and abort has priority over flush and pop.
REQ-025 abort in HOLD SHALL be ignored; a completed block is always delivered.
REQ-026 flush asserted in HOLD SHALL only set flush_pend.

Reset
REQ-027 n_rst=0 at a clk edge SHALL force FILL, byte_count=0, block_data=0, block_valid=0, block_last=0, fifo_r_enable=0 and flush_pend=0, including mid-fill and mid-HOLD.

Structure
REQ-028 Package rx_ctrl_pkg SHALL hold the state enum (FILL, HOLD), BLOCK_BYTES and the block width constant (128).
REQ-029 No sub-module is required; the block SHALL connect one-to-one to rx_fifo read-side ports at the receiver top level.

Verification
REQ-030 Bench SHALL cover: 16 bytes 0x00..0x0F preloaded, block_ready=1 -> 16 consecutive pops, then block_valid with block_data=0x000102..0F and block_last=0.
REQ-031 Bench SHALL cover: 5 bytes 0xA1..0xA5, then flush -> block_data=0xA1A2A3A4A5 followed by 11 zero bytes, and block_last=1.
REQ-032 Bench SHALL cover: block_ready=0 for 10 cycles in HOLD -> block_data stable, fifo_r_enable=0 throughout, and FIFO occupancy unchanged.
REQ-033 Bench SHALL cover: 7 bytes then abort, then 16 bytes 0x10..0x1F -> only a block of 0x10..0x1F is emitted.
REQ-034 Bench SHALL cover: n_rst low after 9 bytes -> all outputs at reset values next cycle and byte_count=0.
REQ-035 Bench SHALL cover: flush with empty FIFO and byte_count=0 -> no block_valid and flush_pend cleared.
